mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Shared memory port bundle: fetch side, MEM-stage side and memory side.
// The slave modport is the arbiter's view; master is the environment's.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready_n;
    logic [31:0] inst_data;

    logic        data_req;
    logic        data_write;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready_n;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready_n;
    logic [31:0] mem_rdata;

    logic [1:0]  owner;

    modport slave (
        input  inst_req, inst_addr,
        output inst_ready_n, inst_data,
        input  data_req, data_write, data_size,
        input  data_addr, data_wdata,
        output data_ready_n, data_rdata,
        output mem_req, mem_write, mem_size,
        output mem_addr, mem_wdata,
        input  mem_ready_n, mem_rdata,
        output owner
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_ready_n, inst_data,
        output data_req, data_write, data_size,
        output data_addr, data_wdata,
        input  data_ready_n, data_rdata,
        input  mem_req, mem_write, mem_size,
        input  mem_addr, mem_wdata,
        output mem_ready_n, mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single memory port: data-priority with a
// fairness counter so fetch is never starved for more than three grants.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INST = 2'b01,
        DATA = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] data_cnt;
    logic [1:0] data_cnt_nxt;
    logic       starve;
    logic       done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            data_cnt <= data_cnt_nxt;
        end
    end

    assign starve = (data_cnt == 2'd3) && bus.inst_req;
    assign done   = !bus.mem_ready_n;

    always_comb begin
        state_nxt    = state;
        data_cnt_nxt = data_cnt;
        unique case (state)
            IDLE: begin
                if (bus.data_req && !starve) begin
                    state_nxt = DATA;
                    // Count only data grants that made a waiting fetch wait
                    if (!bus.inst_req)
                        data_cnt_nxt = 2'd0;
                    else if (data_cnt != 2'd3)
                        data_cnt_nxt = data_cnt + 2'd1;
                end else if (bus.inst_req) begin
                    state_nxt    = INST;
                    data_cnt_nxt = 2'd0;
                end else begin
                    data_cnt_nxt = 2'd0;
                end
            end
            INST, DATA: begin
                if (done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_size     = 2'b00;
        bus.mem_addr     = 32'd0;
        bus.mem_wdata    = 32'd0;
        bus.inst_ready_n = 1'b1;
        bus.inst_data    = 32'd0;
        bus.data_ready_n = 1'b1;
        bus.data_rdata   = 32'd0;
        unique case (state)
            INST: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.inst_addr;
                if (done) begin
                    bus.inst_ready_n = 1'b0;
                    bus.inst_data    = bus.mem_rdata;
                end
            end
            DATA: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = bus.data_write;
                bus.mem_size  = bus.data_size;
                bus.mem_addr  = bus.data_addr;
                bus.mem_wdata = bus.data_wdata;
                if (done) begin
                    bus.data_ready_n = 1'b0;
                    bus.data_rdata   = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.owner = state;

endmodule
